// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
//   It feeds a four-digit seven-segment display driver. A conversion takes
//   DATA_W clock cycles, one input bit per cycle. The published result only
//   changes on the Done edge, so the display never sees a partially shifted
//   value.
//
// Parameters
//   DATA_W   width of the unsigned binary input. The legal range is 1..13,
//            because 2^13-1 = 8191 still fits in four BCD digits.
//   AUTO     0: convert only on Start.
//            1: also start by itself when Data_Bin differs from the last
//               value that was converted.
//
// Ports
//   Sys_CLK   in   1       system clock; all state changes on the rising edge
//   Sys_RST   in   1       asynchronous, active-high reset
//   Start     in   1       conversion request; only sampled while idle
//   Data_Bin  in   DATA_W  unsigned binary value; captured when a request is
//                          accepted
//   Busy      out  1       high while a conversion is in progress
//   Done      out  1       one-cycle pulse; BCD_Out is updated on the same edge
//   BCD_Out   out  16      [3:0]=ones [7:4]=tens [11:8]=hundreds
//                          [15:12]=thousands
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int DATA_W = 8,
  parameter bit AUTO   = 1'b0
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data_Bin,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       BCD_Out
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [15:0]         scratch_q, scratch_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                request;
  logic [15:0]         scratch_adj;
  logic [15+DATA_W:0]  shifted;

  // Add-3 correction on every digit, applied before the shift. A digit of
  // 5..9 becomes 8..12, and the following shift carries its top bit into the
  // next digit. This keeps every digit in the range 0..9.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                      ? scratch_q[4*gi +: 4] + 4'd3
                                      : scratch_q[4*gi +: 4];
    end
  endgenerate

  // The corrected digits and the remaining input bits shift left as one
  // register, so the MSB of the data enters the ones digit first.
  assign shifted = {scratch_adj, shift_q} << 1;

  // In AUTO mode the converter also starts when the input differs from the
  // value it converted last.
  assign request = Start | (AUTO & (Data_Bin != last_q));

  // ---- state register ------------------------------------------------------
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- datapath next values ------------------------------------------------
  always_comb begin
    shift_d   = shift_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          shift_d   = Data_Bin;
          last_d    = Data_Bin;
          scratch_d = 16'h0000;
          cnt_d     = 4'(DATA_W);
        end
      end
      SHIFT: begin
        scratch_d = shifted[15+DATA_W -: 16];
        shift_d   = shifted[DATA_W-1:0];
        cnt_d     = cnt_q - 4'd1;
        // On the last bit, the freshly shifted scratch value is the result.
        // It is published directly, so no extra cycle is spent.
        if (cnt_q == 4'd1) begin
          bcd_d  = shifted[15+DATA_W -: 16];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      shift_q   <= '0;
      last_q    <= '0;
      scratch_q <= 16'h0000;
      bcd_q     <= 16'h0000;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  // ---- outputs -------------------------------------------------------------
  always_comb begin
    Busy    = (state_q == SHIFT);
    Done    = done_q;
    BCD_Out = bcd_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Directed test of bin_to_bcd_seq with DATA_W=8. One instance uses AUTO=0
//   (index 0). A second instance uses AUTO=1 (index 1).
//
//   An arithmetic model predicts Busy, Done and BCD_Out for both instances.
//   The model converts by decimal division, not by shifting. A compare
//   process checks both instances against the model on every falling edge.
//   The directed tests also check hand-computed literal results and
//   Busy-cycle counts, which pin down the model itself.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r [2];
  logic [7:0]  data_r  [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [15:0] bcd_w   [2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.DATA_W(8), .AUTO(1'b0)) u_man (
    .Sys_CLK (clk),
    .Sys_RST (rst),
    .Start   (start_r[0]),
    .Data_Bin(data_r[0]),
    .Busy    (busy_w[0]),
    .Done    (done_w[0]),
    .BCD_Out (bcd_w[0])
  );

  bin_to_bcd_seq #(.DATA_W(8), .AUTO(1'b1)) u_auto (
    .Sys_CLK (clk),
    .Sys_RST (rst),
    .Start   (start_r[1]),
    .Data_Bin(data_r[1]),
    .Busy    (busy_w[1]),
    .Done    (done_w[1]),
    .BCD_Out (bcd_w[1])
  );

  // ---- reference model -----------------------------------------------------
  // Decimal digits of an integer, packed four bits per digit.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  bit          m_busy [2];
  bit          m_done [2];
  logic [15:0] m_bcd  [2];
  int          m_left [2];
  int          m_val  [2];
  int          m_last [2];

  // A conversion accepted at edge E0 produces its result at edge E0+8.
  // While a conversion is busy, all requests are ignored.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_bcd[i]  = 16'h0000;
        m_left[i] = 0;
        m_val[i]  = 0;
        m_last[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_bcd[i]  = to_bcd(m_val[i]);
          end
        end else if (start_r[i] || (i == 1 && int'(data_r[i]) != m_last[i])) begin
          m_busy[i] = 1'b1;
          m_left[i] = 8;
          m_val[i]  = int'(data_r[i]);
          m_last[i] = int'(data_r[i]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- per-cycle compare ---------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy[%0d]", i), 16'(busy_w[i]), 16'(m_busy[i]));
      check($sformatf("done[%0d]", i), 16'(done_w[i]), 16'(m_done[i]));
      check($sformatf("bcd[%0d]", i),  bcd_w[i],       m_bcd[i]);
    end
  end

  // ---- stimulus helpers ----------------------------------------------------
  task automatic pulse(input int idx, input logic [7:0] v);
    @(posedge clk); #1;
    data_r[idx]  = v;
    start_r[idx] = 1'b1;
    @(posedge clk); #1;
    start_r[idx] = 1'b0;
  endtask

  // Waits for the next Done on instance idx, then checks the result against
  // a literal. Also returns the number of Busy cycles seen before the Done.
  task automatic wait_done(input int idx, input logic [15:0] exp, input string name,
                           output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done_w[idx]) begin
        seen = 1'b1;
        check(name, bcd_w[idx], exp);
        $display("conv %s: inst %0d BCD_Out=%h busy_cycles=%0d", name, idx, bcd_w[idx], busy_cycles);
      end else if (busy_w[idx]) begin
        busy_cycles++;
      end
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: got no Done within 30 cycles, expected Done", name);
    end
  endtask

  task automatic expect_no_done(input int idx, input int ncyc, input string name);
    int cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (done_w[idx]) cnt++;
    end
    check(name, 16'(cnt), 16'd0);
  endtask

  // ---- directed tests ------------------------------------------------------
  initial begin
    int bc;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0;
      data_r[i]  = 8'd0;
    end
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", 16'(busy_w[i]), 16'd0);
      check("reset_done", 16'(done_w[i]), 16'd0);
      check("reset_bcd",  bcd_w[i],       16'h0000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: 255, with Busy lasting exactly 8 cycles
    pulse(0, 8'd255);
    wait_done(0, 16'h0255, "t1_255", bc);
    check("t1_busy_cycles", 16'(bc), 16'd8);

    // 2: sequential conversions, including zero
    pulse(0, 8'd0);
    wait_done(0, 16'h0000, "t2_0", bc);
    check("t2_zero_busy_cycles", 16'(bc), 16'd8);
    pulse(0, 8'd99);
    wait_done(0, 16'h0099, "t2_99", bc);
    pulse(0, 8'd100);
    wait_done(0, 16'h0100, "t2_100", bc);

    // 3: a Start re-pulsed during Busy is ignored
    pulse(0, 8'd37);
    repeat (2) @(negedge clk);
    pulse(0, 8'd200);
    wait_done(0, 16'h0037, "t3_37", bc);
    expect_no_done(0, 15, "t3_single_done");

    // 4: asynchronous reset in the middle of a shift
    pulse(0, 8'd128);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_busy_async", 16'(busy_w[0]), 16'd0);
    check("t4_bcd_async",  bcd_w[0],       16'h0000);
    #1 rst = 1'b0;
    expect_no_done(0, 20, "t4_no_done");

    // 5: Start held high; the new data is presented in the Done cycle
    @(posedge clk); #1;
    data_r[0]  = 8'd1;
    start_r[0] = 1'b1;
    wait_done(0, 16'h0001, "t5_1", bc);
    data_r[0] = 8'd254;
    wait_done(0, 16'h0254, "t5_254", bc);
    start_r[0] = 1'b0;
    repeat (12) @(negedge clk);

    // 6: AUTO instance starts itself on a change of input
    @(posedge clk); #1;
    data_r[1] = 8'd42;
    wait_done(1, 16'h0042, "t6_42", bc);
    check("t6_busy_cycles", 16'(bc), 16'd8);
    expect_no_done(1, 25, "t6_steady_no_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
